// File: rtl/sched_pieo_deq_responder.sv
// Dequeue-side PIEO responder: unsorted slot array, extracts min-rank eligible element per trigger.
// Latency: trigger at edge T -> SEARCH in T+1, deq_valid_out in T+2, ready again in T+3.
// Backpressure: enq_ready_out low outside IDLE or when full; triggers outside IDLE are ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enq_valid_in/enq_element_in/enq_ready_out   enqueue valid/ready port
//   time_now_in         current scheduler time (sampled in SEARCH)
//   deq_trigger_in      dequeue request pulse; pieo_ready_for_deq high only in IDLE
//   pieo_empty          registered (count == 0)
//   deq_valid_out/deq_element_out   one-cycle response (all-ones when nothing eligible)
// Optional: define SCHED_PIEO_STATS_EN to add saturating 16-bit counters
//   stat_deq_ok_out (valid responses) and stat_deq_miss_out (all-ones responses).

module sched_pieo_deq_responder #(
  parameter int NUM_FIFO      = 3,
  parameter int ID_LOG        = $clog2(NUM_FIFO),
  parameter int RANK_LOG      = 1,
  parameter int TIME_LOG      = 1,
  parameter int ELEMENT_WIDTH = ID_LOG + RANK_LOG + TIME_LOG,
  parameter int DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_in,
  input  logic [ELEMENT_WIDTH-1:0] enq_element_in,
  output logic                     enq_ready_out,
  input  logic [TIME_LOG-1:0]      time_now_in,
  input  logic                     deq_trigger_in,
  output logic                     pieo_ready_for_deq,
  output logic                     pieo_empty,
  output logic                     deq_valid_out,
  output logic [ELEMENT_WIDTH-1:0] deq_element_out
`ifdef SCHED_PIEO_STATS_EN
  ,
  output logic [15:0]              stat_deq_ok_out,
  output logic [15:0]              stat_deq_miss_out
`endif
);

  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int RANK_LSB = TIME_LOG;
  localparam int RANK_MSB = TIME_LOG + RANK_LOG - 1;
  localparam logic [CNT_W-1:0]         DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ELEMENT_WIDTH-1:0] INVALID = '1;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_nxt;
  logic [DEPTH-1:0]         slot_vld;
  logic [ELEMENT_WIDTH-1:0] slot_dat [DEPTH];

  logic                     win_found;
  logic [IDX_W-1:0]         win_idx;
  logic [RANK_LOG-1:0]      win_rank;
  logic                     free_found;
  logic [IDX_W-1:0]         free_idx;
  logic                     enq_fire;
  logic                     enq_store;
  logic                     search_win;

  // Winner: strict '<' while scanning upward keeps ties on the lowest index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_rank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && (slot_dat[i][TIME_LOG-1:0] <= time_now_in)) begin
        if (!win_found || (slot_dat[i][RANK_MSB:RANK_LSB] < win_rank)) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
          win_rank  = slot_dat[i][RANK_MSB:RANK_LSB];
        end
      end
    end
  end

  // Lowest free slot: scanning downward so the last hit is the lowest index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_vld[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    enq_fire   = enq_valid_in && enq_ready_out;
    // All-ones is the invalid marker: complete the handshake but do not store it.
    enq_store  = enq_fire && free_found && (enq_element_in != INVALID);
    search_win = (state == SEARCH) && win_found;

    count_nxt = count;
    if (enq_store) begin
      count_nxt = count + 1'b1;
    end else if (search_win) begin
      count_nxt = count - 1'b1;
    end

    state_nxt = state;
    case (state)
      IDLE:    if (deq_trigger_in) state_nxt = SEARCH;
      SEARCH:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      count              <= '0;
      slot_vld           <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_dat[i] <= '0;
      end
      pieo_ready_for_deq <= 1'b1;
      pieo_empty         <= 1'b1;
      enq_ready_out      <= 1'b1;
      deq_valid_out      <= 1'b0;
      deq_element_out    <= '0;
`ifdef SCHED_PIEO_STATS_EN
      stat_deq_ok_out    <= '0;
      stat_deq_miss_out  <= '0;
`endif
    end else begin
      state              <= state_nxt;
      count              <= count_nxt;
      // Status outputs are registered from next-state values so they line up with state.
      pieo_ready_for_deq <= (state_nxt == IDLE);
      pieo_empty         <= (count_nxt == '0);
      enq_ready_out      <= (state_nxt == IDLE) && (count_nxt < DEPTH_C);

      if (enq_store) begin
        slot_vld[free_idx] <= 1'b1;
        slot_dat[free_idx] <= enq_element_in;
      end

      if (state == SEARCH) begin
        deq_valid_out <= 1'b1;
        if (win_found) begin
          slot_vld[win_idx] <= 1'b0;
          deq_element_out   <= slot_dat[win_idx];
        end else begin
          deq_element_out   <= INVALID;
        end
`ifdef SCHED_PIEO_STATS_EN
        if (win_found) begin
          if (stat_deq_ok_out != 16'hFFFF) stat_deq_ok_out <= stat_deq_ok_out + 16'd1;
        end else begin
          if (stat_deq_miss_out != 16'hFFFF) stat_deq_miss_out <= stat_deq_miss_out + 16'd1;
        end
`endif
      end else begin
        deq_valid_out   <= 1'b0;
        deq_element_out <= '0;
      end
    end
  end

endmodule
